// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the decode-side hazard scoreboard.
// Holds the Tuse "unused" code, forward-select codes and the entry record.
package hazard_scoreboard_pkg;

  localparam logic [3:0] NO_USE = 4'd4;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic [3:0] tnew;
  } sb_entry_t;

  function automatic logic [3:0] sat_dec(input logic [3:0] t);
    return (t == '0) ? '0 : t - 4'd1;
  endfunction

  // Advance an entry by one stage: identity kept, remaining Tnew shrinks.
  function automatic sb_entry_t age_entry(input sb_entry_t ent);
    sb_entry_t r;
    r      = ent;
    r.tnew = sat_dec(ent.tnew);
    return r;
  endfunction

  // Register 0 and empty slots never produce a dependency.
  function automatic logic entry_hits(input sb_entry_t ent, input logic [4:0] addr);
    return ent.valid && (ent.addr != '0) && (ent.addr == addr);
  endfunction

endpackage

// File: rtl/hazard_operand_check.sv
// Per-operand dependency check against the E/M/W shadow entries.
// Youngest match wins; it alone decides stall and forward source.
module hazard_operand_check
  import hazard_scoreboard_pkg::*;
#(
  parameter logic [3:0] USE_NONE = 4'd4
) (
  input  logic [4:0] addr,
  input  logic [3:0] tuse,
  input  sb_entry_t  ent_e,
  input  sb_entry_t  ent_m,
  input  sb_entry_t  ent_w,
  output logic       need_stall,
  output logic [1:0] fwd
);

  logic       hit;
  logic [3:0] hit_tnew;
  fwd_sel_e   hit_code;

  always_comb begin
    hit        = 1'b0;
    hit_tnew   = '0;
    hit_code   = FWD_GRF;
    need_stall = 1'b0;
    fwd        = FWD_GRF;

    if ((addr != '0) && (tuse != USE_NONE)) begin
      if (entry_hits(ent_e, addr)) begin
        hit      = 1'b1;
        hit_tnew = ent_e.tnew;
        hit_code = FWD_E;
      end else if (entry_hits(ent_m, addr)) begin
        hit      = 1'b1;
        hit_tnew = ent_m.tnew;
        hit_code = FWD_M;
      end else if (entry_hits(ent_w, addr)) begin
        hit      = 1'b1;
        hit_tnew = ent_w.tnew;
        hit_code = FWD_W;
      end
    end

    // A not-yet-ready youngest producer leaves fwd at GRF; later stages resolve it.
    if (hit) begin
      need_stall = (hit_tnew > tuse);
      if (hit_tnew == '0) begin
        fwd = hit_code;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard unit: E/M/W shadow scoreboard, global stall,
// ID-stage forward selects and a stall-cycle counter.
module hazard_scoreboard #(
  parameter logic [3:0]  NO_USE = hazard_scoreboard_pkg::NO_USE,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       rs_addr_id,
  input  logic [4:0]       rt_addr_id,
  input  logic [3:0]       rs_use_id,
  input  logic [3:0]       rt_use_id,
  input  logic [4:0]       dst_addr_id,
  input  logic [3:0]       dst_save_id,
  output logic             stall,
  output logic             pc_enable,
  output logic             id_enable,
  output logic [1:0]       fwd_rs_id,
  output logic [1:0]       fwd_rt_id,
  output logic [CNT_W-1:0] stall_cycles
);
  import hazard_scoreboard_pkg::*;

  sb_entry_t ent_e, ent_m, ent_w;
  sb_entry_t ent_e_next;
  logic      rs_stall, rt_stall;

  hazard_operand_check #(.USE_NONE(NO_USE)) u_rs_check (
    .addr       (rs_addr_id),
    .tuse       (rs_use_id),
    .ent_e      (ent_e),
    .ent_m      (ent_m),
    .ent_w      (ent_w),
    .need_stall (rs_stall),
    .fwd        (fwd_rs_id)
  );

  hazard_operand_check #(.USE_NONE(NO_USE)) u_rt_check (
    .addr       (rt_addr_id),
    .tuse       (rt_use_id),
    .ent_e      (ent_e),
    .ent_m      (ent_m),
    .ent_w      (ent_w),
    .need_stall (rt_stall),
    .fwd        (fwd_rt_id)
  );

  always_comb begin
    stall     = dec_valid && (rs_stall || rt_stall);
    pc_enable = ~stall;
    id_enable = ~stall;
  end

  // Tnew is stored already aged by the ID->E hop; a stall injects a bubble.
  always_comb begin
    ent_e_next = '0;
    if (!stall && dec_valid) begin
      ent_e_next.valid = 1'b1;
      ent_e_next.addr  = dst_addr_id;
      ent_e_next.tnew  = sat_dec(dst_save_id);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_e        <= '0;
      ent_m        <= '0;
      ent_w        <= '0;
      stall_cycles <= '0;
    end else begin
      ent_e <= ent_e_next;
      ent_m <= age_entry(ent_e);
      ent_w <= age_entry(ent_m);
      if (stall) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: hand-computed stall/forward/counter values.
module tb_hazard_scoreboard;
  localparam logic [3:0] NU = 4'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  rs_addr_id, rt_addr_id, dst_addr_id;
  logic [3:0]  rs_use_id, rt_use_id, dst_save_id;
  logic        stall, pc_enable, id_enable;
  logic [1:0]  fwd_rs_id, fwd_rt_id;
  logic [31:0] stall_cycles;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  hazard_scoreboard #(.NO_USE(4'd4), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .rs_addr_id   (rs_addr_id),
    .rt_addr_id   (rt_addr_id),
    .rs_use_id    (rs_use_id),
    .rt_use_id    (rt_use_id),
    .dst_addr_id  (dst_addr_id),
    .dst_save_id  (dst_save_id),
    .stall        (stall),
    .pc_enable    (pc_enable),
    .id_enable    (id_enable),
    .fwd_rs_id    (fwd_rs_id),
    .fwd_rt_id    (fwd_rt_id),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic [4:0] rs, input logic [3:0] rsu,
                       input logic [4:0] rt, input logic [3:0] rtu,
                       input logic [4:0] dst, input logic [3:0] ds);
    dec_valid   = dv;
    rs_addr_id  = rs;
    rs_use_id   = rsu;
    rt_addr_id  = rt;
    rt_use_id   = rtu;
    dst_addr_id = dst;
    dst_save_id = ds;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, NU, 5'd0, NU, 5'd0, 4'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_pc_en", 32'(pc_enable), 32'd1);
    check("rst_id_en", 32'(id_enable), 32'd1);
    check("rst_fwd_rs", 32'(fwd_rs_id), 32'd0);
    check("rst_fwd_rt", 32'(fwd_rt_id), 32'd0);
    check("rst_cnt", stall_cycles, 32'd0);

    // lw $8 (Tnew 3) followed by addu reading $8 at Tuse 1
    drive(1'b1, 5'd0, NU, 5'd0, NU, 5'd8, 4'd3);
    check("lw_issue_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 5'd8, 4'd1, 5'd0, NU, 5'd10, 4'd2);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_pc_en", 32'(pc_enable), 32'd0);
    check("lu_id_en", 32'(id_enable), 32'd0);
    tick();
    check("lu_release", 32'(stall), 32'd0);
    check("lu_fwd_rs_m_notready", 32'(fwd_rs_id), 32'd0);
    check("lu_cnt", stall_cycles, 32'd1);
    tick();
    // E={10,1} M=empty W={8,0}
    drive(1'b1, 5'd8, 4'd1, 5'd10, 4'd0, 5'd0, 4'd0);
    check("br_stall", 32'(stall), 32'd1);
    check("w_fwd_rs", 32'(fwd_rs_id), 32'd3);
    check("br_fwd_rt_e_notready", 32'(fwd_rt_id), 32'd0);
    tick();
    check("br_release", 32'(stall), 32'd0);
    check("br_fwd_rs_gone", 32'(fwd_rs_id), 32'd0);
    check("br_fwd_rt_m", 32'(fwd_rt_id), 32'd2);
    check("br_cnt", stall_cycles, 32'd2);
    tick();

    // $0 never matches
    drive(1'b1, 5'd0, 4'd0, 5'd0, 4'd0, 5'd0, 4'd3);
    check("z0_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 5'd0, 4'd0, 5'd0, 4'd0, 5'd0, 4'd0);
    check("z1_stall", 32'(stall), 32'd0);
    check("z1_fwd_rs", 32'(fwd_rs_id), 32'd0);
    check("z1_fwd_rt", 32'(fwd_rt_id), 32'd0);
    tick();

    // E={4,0} and M={4,0}: E shadows M; same reg on rs and rt
    drive(1'b1, 5'd0, NU, 5'd0, NU, 5'd4, 4'd1);
    tick();
    drive(1'b1, 5'd0, NU, 5'd0, NU, 5'd4, 4'd0);
    tick();
    drive(1'b1, 5'd4, 4'd1, 5'd4, 4'd1, 5'd0, 4'd0);
    check("sh_stall", 32'(stall), 32'd0);
    check("sh_fwd_rt_e", 32'(fwd_rt_id), 32'd1);
    check("sh_fwd_rs_e", 32'(fwd_rs_id), 32'd1);
    tick();

    // E={4,2} shadows ready M={4,0}
    drive(1'b1, 5'd0, NU, 5'd0, NU, 5'd4, 4'd1);
    tick();
    drive(1'b1, 5'd0, NU, 5'd0, NU, 5'd4, 4'd3);
    tick();
    drive(1'b1, 5'd4, 4'd0, 5'd0, NU, 5'd0, 4'd0);
    check("shs_stall", 32'(stall), 32'd1);
    check("shs_cnt", stall_cycles, 32'd2);
    tick();
    // M={4,1} now shadows W={4,0}
    check("shs2_stall", 32'(stall), 32'd1);
    check("shs2_fwd_rs", 32'(fwd_rs_id), 32'd0);
    check("shs2_cnt", stall_cycles, 32'd3);

    // reset while stalled
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rms_stall", 32'(stall), 32'd0);
    check("rms_fwd_rs", 32'(fwd_rs_id), 32'd0);
    check("rms_cnt", stall_cycles, 32'd0);
    check("rms_pc_en", 32'(pc_enable), 32'd1);

    // NO_USE operand ignores a pending producer
    drive(1'b1, 5'd0, NU, 5'd0, NU, 5'd9, 4'd4);
    check("nu_issue_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 5'd9, NU, 5'd0, NU, 5'd0, 4'd0);
    check("nu_stall", 32'(stall), 32'd0);
    check("nu_fwd_rs", 32'(fwd_rs_id), 32'd0);
    tick();
    // ID bubble never stalls even with M={9,2}
    drive(1'b0, 5'd9, 4'd0, 5'd0, NU, 5'd0, 4'd0);
    check("bub_stall", 32'(stall), 32'd0);
    tick();
    check("bub_cnt", stall_cycles, 32'd0);
    // W={9,1} still pending for Tuse 0
    drive(1'b1, 5'd9, 4'd0, 5'd0, NU, 5'd0, 4'd0);
    check("w_stall", 32'(stall), 32'd1);
    check("w_fwd_rs", 32'(fwd_rs_id), 32'd0);
    tick();
    check("w_cnt", stall_cycles, 32'd1);
    check("w_release", 32'(stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
